// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the AXI read arbiter slice.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] BURST_WRAP = 2'h2;
    localparam logic [2:0] SIZE_8B    = 3'h3;

    // Width of a requester index; never below one bit so N_REQ=1 still elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Requester-side (s_*) and downstream (m_*) AXI4 read signals for the arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on AR and R. The slave modport is the arbiter; master is the environment.
interface axi_read_arbiter_if #(
    parameter int N_REQ      = 2,
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    // Per-requester AR channel, one packed slice per requester
    logic [N_REQ-1:0][ID_WIDTH-1:0]   s_axi_arid;
    logic [N_REQ-1:0][ADDR_WIDTH-1:0] s_axi_araddr;
    logic [N_REQ-1:0][7:0]            s_axi_arlen;
    logic [N_REQ-1:0][2:0]            s_axi_arsize;
    logic [N_REQ-1:0][1:0]            s_axi_arburst;
    logic [N_REQ-1:0]                 s_axi_arlock;
    logic [N_REQ-1:0][3:0]            s_axi_arcache;
    logic [N_REQ-1:0][2:0]            s_axi_arprot;
    logic [N_REQ-1:0]                 s_axi_arvalid;
    logic [N_REQ-1:0]                 s_axi_arready;

    // Broadcast R payload, per-requester handshake
    logic [ID_WIDTH-1:0]              s_axi_rid;
    logic [DATA_WIDTH-1:0]            s_axi_rdata;
    logic [1:0]                       s_axi_rresp;
    logic                             s_axi_rlast;
    logic [N_REQ-1:0]                 s_axi_rvalid;
    logic [N_REQ-1:0]                 s_axi_rready;

    // Downstream AR channel
    logic [ID_WIDTH-1:0]              m_axi_arid;
    logic [ADDR_WIDTH-1:0]            m_axi_araddr;
    logic [7:0]                       m_axi_arlen;
    logic [2:0]                       m_axi_arsize;
    logic [1:0]                       m_axi_arburst;
    logic                             m_axi_arlock;
    logic [3:0]                       m_axi_arcache;
    logic [2:0]                       m_axi_arprot;
    logic                             m_axi_arvalid;
    logic                             m_axi_arready;

    // Downstream R channel
    logic [ID_WIDTH-1:0]              m_axi_rid;
    logic [DATA_WIDTH-1:0]            m_axi_rdata;
    logic [1:0]                       m_axi_rresp;
    logic                             m_axi_rlast;
    logic                             m_axi_rvalid;
    logic                             m_axi_rready;

    modport slave (
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arvalid, s_axi_rready,
               m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
               m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready
    );

    modport master (
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arvalid, s_axi_rready,
               m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
               m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready
    );

endinterface

// File: rtl/axi_read_arbiter_arb_pick.sv
// Combinational requester selector; ARB_ROUND_ROBIN_EN selects round-robin, otherwise fixed priority.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller samples idx/found only when it is ready to grant.
module arb_pick
    import axi_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] cand;

    // Search starts just after the previous winner and wraps; first active request wins
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(last) + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
`else
    // History is irrelevant in fixed-priority mode
    logic unused_last;
    assign unused_last = ^last;

    // Lowest active index wins
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read port among N_REQ requesters, one outstanding burst; ARB_ROUND_ROBIN_EN picks round-robin.
// Latency: 1 cycle IDLE->ADDR arbitration, then AR and R pass through combinationally.
// Backpressure: AR ready and R ready pass straight through to/from the granted requester only.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    axi_read_arbiter_if.slave  bus,
    output logic               busy
);

    localparam int IDX_W = idx_width(N_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
    } ar_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } r_t;

    arb_state_t       state, state_nxt;
    idx_t             grant, grant_nxt;
    idx_t             last_grant, last_nxt;
    logic [7:0]       beat_cnt, beat_nxt;

    idx_t             pick_idx;
    logic             pick_found;
    logic             grant_arvld;
    logic             r_hs;
    logic [N_REQ-1:0] ar_rdy_vec;
    logic [N_REQ-1:0] r_vld_vec;
    ar_t              ar_sel;
    r_t               r_pass;

    arb_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.s_axi_arvalid),
        .last  (last_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign grant_arvld = bus.s_axi_arvalid[grant];
    assign r_hs        = bus.m_axi_rvalid && bus.s_axi_rready[grant];

    // State, grant, arbitration history and beat counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= idx_t'(N_REQ - 1);
            beat_cnt   <= 8'd0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_nxt;
            beat_cnt   <= beat_nxt;
        end
    end

    // Next-state: grant in IDLE, wait for AR acceptance in ADDR, count beats to rlast in DATA
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last_grant;
        beat_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_nxt = pick_idx;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                // A withdrawn request abandons the grant without any transfer
                if (!grant_arvld) begin
                    state_nxt = IDLE;
                end else if (bus.m_axi_arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    beat_nxt = beat_cnt + 8'd1;
                    if (bus.m_axi_rlast) begin
                        state_nxt = IDLE;
                        last_nxt  = grant;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-requester handshake steering: only the granted slice ever sees ready/valid
    always_comb begin
        ar_rdy_vec = '0;
        r_vld_vec  = '0;
        if (state == ADDR) ar_rdy_vec[grant] = bus.m_axi_arready;
        if (state == DATA) r_vld_vec[grant]  = bus.m_axi_rvalid;
    end

    // AR fields always follow the granted slice; R payload is broadcast unchanged
    always_comb begin
        ar_sel.id    = bus.s_axi_arid[grant];
        ar_sel.addr  = bus.s_axi_araddr[grant];
        ar_sel.len   = bus.s_axi_arlen[grant];
        ar_sel.size  = bus.s_axi_arsize[grant];
        ar_sel.burst = bus.s_axi_arburst[grant];
        ar_sel.lock  = bus.s_axi_arlock[grant];
        ar_sel.cache = bus.s_axi_arcache[grant];
        ar_sel.prot  = bus.s_axi_arprot[grant];
        r_pass.id    = bus.m_axi_rid;
        r_pass.data  = bus.m_axi_rdata;
        r_pass.resp  = bus.m_axi_rresp;
        r_pass.last  = bus.m_axi_rlast;
    end

    assign bus.m_axi_arid    = ar_sel.id;
    assign bus.m_axi_araddr  = ar_sel.addr;
    assign bus.m_axi_arlen   = ar_sel.len;
    assign bus.m_axi_arsize  = ar_sel.size;
    assign bus.m_axi_arburst = ar_sel.burst;
    assign bus.m_axi_arlock  = ar_sel.lock;
    assign bus.m_axi_arcache = ar_sel.cache;
    assign bus.m_axi_arprot  = ar_sel.prot;
    assign bus.m_axi_arvalid = (state == ADDR) && grant_arvld;
    assign bus.s_axi_arready = ar_rdy_vec;

    assign bus.s_axi_rid     = r_pass.id;
    assign bus.s_axi_rdata   = r_pass.data;
    assign bus.s_axi_rresp   = r_pass.resp;
    assign bus.s_axi_rlast   = r_pass.last;
    assign bus.s_axi_rvalid  = r_vld_vec;
    assign bus.m_axi_rready  = (state == DATA) && bus.s_axi_rready[grant];

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed self-checking bench for axi_read_arbiter with two requesters.
// Latency: drives inputs 1 time unit after posedge and samples 1-2 units later.
// Backpressure: exercises AR stall, R ready toggling, withdrawal and mid-burst reset.
module tb_axi_read_arbiter;
    import axi_arb_pkg::*;

    localparam int N   = 2;
    localparam int IDW = 13;
    localparam int AW  = 64;
    localparam int DW  = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy;
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;
    int   got;
    logic [7:0] cnt_before;

    axi_read_arbiter_if #(.N_REQ(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_read_arbiter #(.N_REQ(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // IDLE cycle with request(s) up, then ADDR with immediate downstream acceptance
    task automatic grant_req(input int exp, input logic [63:0] exp_addr);
        logic [1:0] oh;
        oh = 2'b01 << exp;
        #1;
        check("idle_no_arvalid", bus.m_axi_arvalid, 0);
        check("idle_no_arready", bus.s_axi_arready, 0);
        step();
        bus.m_axi_arready = 1'b1;
        #1;
        check("addr_arvalid", bus.m_axi_arvalid, 1);
        check("addr_araddr", bus.m_axi_araddr, exp_addr);
        check("addr_arready_onehot", bus.s_axi_arready, oh);
        step();
        bus.m_axi_arready = 1'b0;
    endtask

    // Downstream memory model: streams base+k, rlast on beat n-1, stops after nstop handshakes
    task automatic serve(input int req, input int n, input int nstop, input logic [7:0] base,
                         input bit toggle, output int delivered);
        int k;
        int cyc;
        logic [1:0]  oh;
        logic [63:0] ev;
        k   = 0;
        cyc = 0;
        oh  = 2'b01 << req;
        while (k < nstop && cyc < 64) begin
            ev = 64'(base) + 64'(k);
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = ev;
            bus.m_axi_rlast  = (k == n - 1);
            bus.m_axi_rid    = bus.s_axi_arid[req];
            bus.s_axi_rready = 2'b11;
            if (toggle) bus.s_axi_rready[req] = ((cyc % 2) == 0);
            #1;
            check("r_valid_route", bus.s_axi_rvalid, oh);
            check("r_ready_mirror", bus.m_axi_rready, bus.s_axi_rready[req]);
            check("r_data", bus.s_axi_rdata, ev);
            check("data_arready_quiet", bus.s_axi_arready, 0);
            if (bus.s_axi_rready[req]) k++;
            step();
            cyc++;
        end
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        bus.s_axi_rready = 2'b00;
        delivered = k;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int seq[3];
        bus.s_axi_arid    = '0;
        bus.s_axi_arid[0] = 13'h0a1;
        bus.s_axi_arid[1] = 13'h1b2;
        bus.s_axi_araddr  = '0;
        bus.s_axi_araddr[0] = 64'h1000;
        bus.s_axi_araddr[1] = 64'h2000;
        bus.s_axi_arlen   = '0;
        bus.s_axi_arlen[0] = 8'd7;
        bus.s_axi_arlen[1] = 8'd7;
        bus.s_axi_arsize  = {SIZE_8B, SIZE_8B};
        bus.s_axi_arburst = {BURST_WRAP, BURST_WRAP};
        bus.s_axi_arlock  = '0;
        bus.s_axi_arcache = '0;
        bus.s_axi_arprot  = '0;
        bus.s_axi_arvalid = '0;
        bus.s_axi_rready  = '0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rid     = '0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = '0;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rvalid  = 1'b0;

        // Reset values
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_s_arready", bus.s_axi_arready, 0);
        check("rst_s_rvalid", bus.s_axi_rvalid, 0);
        check("rst_m_arvalid", bus.m_axi_arvalid, 0);
        check("rst_m_rready", bus.m_axi_rready, 0);
        check("rst_state", 64'(dut.state), 64'(IDLE));
        check("rst_grant", 64'(dut.grant), 0);
        check("rst_last_grant", 64'(dut.last_grant), 1);
        check("rst_beat_cnt", 64'(dut.beat_cnt), 0);
        check("rst_araddr_slice0", bus.m_axi_araddr, 64'h1000);
        reset = 1'b0;

        // Single icache burst, downstream AR accepted after two stall cycles
        bus.s_axi_arvalid = 2'b01;
        #1;
        check("t1_idle_arvalid", bus.m_axi_arvalid, 0);
        step();
        check("t1_busy_addr", busy, 1);
        check("t1_arvalid", bus.m_axi_arvalid, 1);
        check("t1_araddr", bus.m_axi_araddr, 64'h1000);
        check("t1_arlen", bus.m_axi_arlen, 7);
        check("t1_arid", bus.m_axi_arid, 13'h0a1);
        check("t1_arready_stall", bus.s_axi_arready, 0);
        step();
        step();
        bus.m_axi_arready = 1'b1;
        #1;
        check("t1_arready", bus.s_axi_arready, 2'b01);
        step();
        bus.s_axi_arvalid = 2'b00;
        bus.m_axi_arready = 1'b0;
        #1;
        check("t1_data_arvalid", bus.m_axi_arvalid, 0);
        serve(0, 8, 8, 8'h10, 1'b0, got);
        check("t1_beats", got, 8);
        check("t1_beat_cnt", 64'(dut.beat_cnt), 8);
        check("t1_busy_drop", busy, 0);

        // Both requesters together, both held throughout
        do_reset();
`ifdef ARB_ROUND_ROBIN_EN
        seq = '{0, 1, 0};
`else
        seq = '{0, 0, 0};
`endif
        bus.s_axi_arvalid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            grant_req(seq[i], (seq[i] == 0) ? 64'h1000 : 64'h2000);
            serve(seq[i], 1, 1, 8'h20 + 8'(i), 1'b0, got);
            check("t2_beats", got, 1);
        end
        bus.s_axi_arvalid = 2'b00;

        // dcache burst with R ready toggling every cycle
        bus.s_axi_arvalid = 2'b10;
        grant_req(1, 64'h2000);
        bus.s_axi_arvalid = 2'b00;
        cnt_before = dut.beat_cnt;
        serve(1, 8, 8, 8'hA0, 1'b1, got);
        check("t3_beats", got, 8);
        check("t3_beat_cnt_delta", 64'(8'(dut.beat_cnt - cnt_before)), 8);
        check("t3_busy_drop", busy, 0);

        // Slice 1 arrives while slice 0 is in DATA
        bus.s_axi_arvalid = 2'b01;
        grant_req(0, 64'h1000);
        bus.s_axi_arvalid = 2'b10;
        serve(0, 4, 4, 8'h30, 1'b0, got);
        check("t4_beats", got, 4);
        check("t4_idle_busy", busy, 0);
        grant_req(1, 64'h2000);
        bus.s_axi_arvalid = 2'b00;
        serve(1, 1, 1, 8'h40, 1'b0, got);
        check("t4_second_beats", got, 1);

        // Reset during beat 4 of 8
        bus.s_axi_arvalid = 2'b01;
        grant_req(0, 64'h1000);
        bus.s_axi_arvalid = 2'b00;
        serve(0, 8, 3, 8'h50, 1'b0, got);
        check("t5_pre_beats", got, 3);
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = 64'h53;
        bus.s_axi_rready = 2'b11;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("t5_state", 64'(dut.state), 64'(IDLE));
        check("t5_busy", busy, 0);
        check("t5_m_rready", bus.m_axi_rready, 0);
        check("t5_s_rvalid", bus.s_axi_rvalid, 0);
        check("t5_m_arvalid", bus.m_axi_arvalid, 0);
        check("t5_s_arready", bus.s_axi_arready, 0);
        check("t5_beat_cnt", 64'(dut.beat_cnt), 0);
        bus.m_axi_rvalid = 1'b0;
        bus.s_axi_rready = 2'b00;
        bus.s_axi_arvalid = 2'b10;
        grant_req(1, 64'h2000);
        bus.s_axi_arvalid = 2'b00;
        serve(1, 2, 2, 8'h60, 1'b0, got);
        check("t5_fresh_beats", got, 2);
        check("t5_fresh_cnt", 64'(dut.beat_cnt), 2);
        check("t5_fresh_busy", busy, 0);

        // Granted request withdrawn in ADDR before arready
        bus.s_axi_arvalid = 2'b01;
        step();
        check("t6_arvalid", bus.m_axi_arvalid, 1);
        bus.s_axi_arvalid = 2'b00;
        #1;
        check("t6_arvalid_drop", bus.m_axi_arvalid, 0);
        step();
        check("t6_state", 64'(dut.state), 64'(IDLE));
        check("t6_busy", busy, 0);
        bus.m_axi_rvalid = 1'b1;
        bus.s_axi_rready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6_no_rready", bus.m_axi_rready, 0);
            check("t6_no_rvalid", bus.s_axi_rvalid, 0);
            step();
        end
        bus.m_axi_rvalid = 1'b0;
        bus.s_axi_rready = 2'b00;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
